fir_bank_tdm: RTL and testbench
===============================

Name: fir_bank_tdm

Overview:
Parametrised, time-multiplexed FIR filter bank with NCH channels that all filter the same input stream. Each accepted sample triggers one MAC pass over the NTAPS-deep history, consuming two taps per cycle per channel from external synchronous coefficient ROMs. Results are rounded and saturated, and an output-valid strobe marks them. Busy/overrun handshake, fill-aware history and signed arithmetic are new relative to the previous filter bank.

Parameters:
NCH, 8, number of filter channels
NTAPS, 128, taps per filter; even, power of two, >=4
DW, 16, sample and output width (signed)
CW, 18, coefficient width (signed)
ACCW, 42, accumulator width (signed)
OSHIFT, 16, right shift applied to the accumulator before output

Ports:
clock  in  1  master clock, rising edge
reset  in  1  asynchronous reset, active high
datain  in  DW  input sample, signed
din_enable  in  1  one-cycle strobe: new sample on datain
busy  out  1  MAC pass in progress; samples are not accepted
coeffaddress  out  log2(NTAPS/2)  shared coefficient ROM address, registered
coeff  in  NCH*2*CW  channel c word at [c*2CW +: 2CW]; low CW bits = h[2a], high CW bits = h[2a+1]
dataout  out  NCH*DW  channel c result at [c*DW +: DW], signed, held between strobes
dout_valid  out  1  one-cycle strobe: dataout updated
overrun  out  1  sticky: a sample was dropped
overrun_clr  in  1  clears overrun

Behaviour:
- Reset is asynchronous and active high. It forces: busy=0, dout_valid=0, overrun=0, dataout=0, coeffaddress=0, wr_ptr=0, fill=0, FSM=IDLE. The history RAM itself is not cleared.
- y_c[n] = sum over k=0..NTAPS-1 of h_c[k]*x[n-k].
- The history is a circular buffer. A tap whose index k satisfies k >= fill contributes 0. fill increments on each accepted sample and saturates at NTAPS.
- FSM states: IDLE, MAC, DRAIN, OUT.
- IDLE: on din_enable at cycle T, write datain at wr_ptr, increment wr_ptr mod NTAPS, clear the accumulators, and go to MAC.
- MAC: coeffaddress = 0..NTAPS/2-1 over cycles T+1..T+NTAPS/2. The ROM has 1-cycle read latency.
- Accumulation: in cycles T+2..T+NTAPS/2+1, each lane adds the two products of word a, using samples at (wr_ptr_new-1-2a) mod NTAPS and (wr_ptr_new-2-2a) mod NTAPS. Wrap-around is mod NTAPS.
- DRAIN: covers the final accumulate cycle.
- OUT: round the accumulator as acc + 2^(OSHIFT-1), arithmetic shift right by OSHIFT, saturate to [-2^(DW-1), 2^(DW-1)-1], register to dataout.
- Timing: dout_valid=1 at cycle T+L with L = NTAPS/2+3 (67 at default), and the FSM returns to IDLE. busy=1 from T+1 through T+L-1.
- A din_enable arriving in the same cycle dout_valid is high is accepted.
- din_enable while busy: the sample is dropped, the history is unchanged, and overrun is set.
- overrun_clr and a new overrun event in the same cycle: overrun remains set.
- All products and sums are signed; the accumulator does not wrap for the default widths.
- reset mid-pass: the pass is aborted immediately, no dout_valid is produced, and history is logically empty (fill=0).

Decomposition:
- Package fir_bank_pkg holds:
  - default parameter constants
  - address-width function clog2(NTAPS/2)
  - FSM state typedef
  - round/saturate function
- Sub-module fir_mac_lane holds one channel's accumulator, two multipliers and round/saturate output register. It is instantiated NCH times.
- The top level owns the FSM, the history buffer, the address counter and the handshake.

Test Plan:
- Impulse response: h_0[k]=65536 for all k; datain=1000 once, then zeros, with samples spaced 80 cycles apart. Expected: dataout ch0 = 1000 for 128 consecutive outputs, then 0. First dout_valid exactly 67 cycles after din_enable.
- Saturation: h_1[k]=65536 for all k, datain=32767 repeated. Expected: ch1 = 32767 from the 2nd output onward. With datain=-32768 repeated, ch1 = -32768.
- Rounding: h_2[0]=32768, other taps 0. datain=3 gives 2; datain=-3 gives -1; datain=1 gives 1.
- Overrun: din_enable at T and T+10. Expected: one dout_valid at T+67 and overrun=1. After overrun_clr, overrun=0. History contains only the first sample.
- Reset mid-pass: assert reset at T+20. Expected: busy=0, dataout=0, no dout_valid. A following impulse of 500 with h_3[k]=k+1 gives ch3 outputs (500*(k+1)+32768)>>16 with no stale history.
- Wrap-around: after 300 samples of a ramp, compare all 8 channels against a golden model at the wr_ptr wrap points.

Source files
------------

// File: rtl/fir_bank_pkg.sv
`timescale 1ns/1ps
// fir_bank_pkg
// Shared definitions for the time-multiplexed FIR filter bank:
//   - default parameter values
//   - clog2() used to size the coefficient address
//   - FSM state type
//   - round_sat(): round-half-up, arithmetic shift and saturate
// No ports (package).
package fir_bank_pkg;

  localparam int NCH_DEF    = 8;
  localparam int NTAPS_DEF  = 128;
  localparam int DW_DEF     = 16;
  localparam int CW_DEF     = 18;
  localparam int ACCW_DEF   = 42;
  localparam int OSHIFT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } fir_state_e;

  // Ceiling log2; evaluated at elaboration time only.
  function automatic int clog2(input int unsigned value);
    int w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

  // Works on a 64-bit sign-extended accumulator so one function serves any
  // ACCW <= 63. Result is in [-2^(dw-1), 2^(dw-1)-1]; callers truncate to dw.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int oshift,
                                                   input int dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (oshift - 1))) >>> oshift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_lane.sv
`timescale 1ns/1ps
// fir_mac_lane
// One filter channel: two signed multipliers feeding a signed accumulator,
// plus the rounded/saturated output register.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   clr_i           clear accumulator (start of a pass)
//   acc_en_i        add this cycle's two products
//   out_en_i        load rounded/saturated result into dout_o
//   x_new_i         sample paired with tap 2a   (already zeroed if unfilled)
//   x_old_i         sample paired with tap 2a+1 (already zeroed if unfilled)
//   coeff_i         {h[2a+1], h[2a]}
//   dout_o          held result
module fir_mac_lane
  import fir_bank_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int CW     = CW_DEF,
  parameter int ACCW   = ACCW_DEF,
  parameter int OSHIFT = OSHIFT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 acc_en_i,
  input  logic                 out_en_i,
  input  logic signed [DW-1:0] x_new_i,
  input  logic signed [DW-1:0] x_old_i,
  input  logic [2*CW-1:0]      coeff_i,
  output logic signed [DW-1:0] dout_o
);

  localparam int PW = DW + CW;

  logic signed [CW-1:0]   h_new;
  logic signed [CW-1:0]   h_old;
  logic signed [PW-1:0]   prod_new;
  logic signed [PW-1:0]   prod_old;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_d;
  logic signed [DW-1:0]   dout_q;
  logic signed [DW-1:0]   dout_d;

  assign h_new = coeff_i[CW-1:0];
  assign h_old = coeff_i[2*CW-1:CW];

  // Operands are sign-extended to the full product width before multiplying.
  assign prod_new = PW'(x_new_i) * PW'(h_new);
  assign prod_old = PW'(x_old_i) * PW'(h_old);

  assign acc_d  = acc_q + ACCW'(prod_new) + ACCW'(prod_old);
  assign dout_d = DW'(round_sat(64'(acc_q), OSHIFT, DW));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      if (clr_i) begin
        acc_q <= '0;
      end else if (acc_en_i) begin
        acc_q <= acc_d;
      end
      if (out_en_i) begin
        dout_q <= dout_d;
      end
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/fir_bank_tdm.sv
`timescale 1ns/1ps
// fir_bank_tdm
// NCH-channel FIR bank sharing one input stream. Each accepted sample starts
// a MAC pass of NTAPS/2 cycles (two taps per cycle per channel) against
// external 1-cycle-latency coefficient ROMs; dout_valid follows the accept
// by NTAPS/2+3 cycles.
// Ports:
//   clock, reset    clock, asynchronous active-high reset
//   datain          signed input sample
//   din_enable      one-cycle new-sample strobe
//   busy            pass in progress, samples dropped
//   coeffaddress    registered shared ROM address
//   coeff           per channel {h[2a+1], h[2a]}
//   dataout         per channel signed result, held between strobes
//   dout_valid      one-cycle result strobe
//   overrun         sticky dropped-sample flag
//   overrun_clr     clears overrun
module fir_bank_tdm
  import fir_bank_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int NTAPS  = NTAPS_DEF,
  parameter int DW     = DW_DEF,
  parameter int CW     = CW_DEF,
  parameter int ACCW   = ACCW_DEF,
  parameter int OSHIFT = OSHIFT_DEF,
  localparam int AW    = clog2(NTAPS / 2)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DW-1:0]       datain,
  input  logic                din_enable,
  output logic                busy,
  output logic [AW-1:0]       coeffaddress,
  input  logic [NCH*2*CW-1:0] coeff,
  output logic [NCH*DW-1:0]   dataout,
  output logic                dout_valid,
  output logic                overrun,
  input  logic                overrun_clr
);

  localparam int PW = AW + 1;   // history pointer width (mod NTAPS)
  localparam int FW = AW + 2;   // fill counter width (0..NTAPS)
  localparam logic [AW-1:0] ADDR_LAST = AW'(NTAPS / 2 - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(NTAPS);

  fir_state_e    state_q;
  logic [PW-1:0] wr_ptr_q;
  logic [FW-1:0] fill_q;
  logic [AW-1:0] addr_q;
  logic          busy_q;
  logic          dout_valid_q;
  logic          overrun_q;
  logic          overrun_d;
  logic          mac_vld_q;
  logic          accept;
  logic          out_en;

  // History is split into even/odd banks so the two samples needed per cycle
  // (always adjacent indices) come from different single-read-port RAMs.
  logic [DW-1:0] hist_even_mem [NTAPS/2];
  logic [DW-1:0] hist_odd_mem  [NTAPS/2];

  logic [PW-1:0] new_idx_d;
  logic [AW-1:0] row_even_d;
  logic [AW-1:0] row_odd_d;
  logic          tap_new_ok_d;
  logic          tap_old_ok_d;

  logic [DW-1:0] rd_even_q;
  logic [DW-1:0] rd_odd_q;
  logic          new_odd_q;
  logic          tap_new_ok_q;
  logic          tap_old_ok_q;

  logic signed [DW-1:0] x_new;
  logic signed [DW-1:0] x_old;

  assign accept = din_enable && (state_q == ST_IDLE);
  assign out_en = (state_q == ST_OUT);

  always_comb begin
    overrun_d = (overrun_q && !overrun_clr) || (din_enable && busy_q);
  end

  // Read addressing for word a = addr_q. wr_ptr_q already points past the
  // newest sample, so tap 2a sits at wr_ptr_q-1-2a and tap 2a+1 one below it.
  // The even bank row is always new_idx>>1; the odd row steps back one row
  // when the newer sample is the even one.
  always_comb begin
    new_idx_d    = wr_ptr_q - PW'(1) - {addr_q, 1'b0};
    row_even_d   = new_idx_d[PW-1:1];
    row_odd_d    = new_idx_d[PW-1:1] - AW'(!new_idx_d[0]);
    tap_new_ok_d = ({1'b0, addr_q, 1'b0} < fill_q);
    tap_old_ok_d = ({1'b0, addr_q, 1'b1} < fill_q);
  end

  // History RAM: write on accept, registered read every cycle. Reads are
  // aligned with the ROM's one-cycle latency.
  always_ff @(posedge clock) begin
    if (accept && !wr_ptr_q[0]) begin
      hist_even_mem[wr_ptr_q[PW-1:1]] <= datain;
    end
    if (accept && wr_ptr_q[0]) begin
      hist_odd_mem[wr_ptr_q[PW-1:1]] <= datain;
    end
    rd_even_q    <= hist_even_mem[row_even_d];
    rd_odd_q     <= hist_odd_mem[row_odd_d];
    new_odd_q    <= new_idx_d[0];
    tap_new_ok_q <= tap_new_ok_d;
    tap_old_ok_q <= tap_old_ok_d;
  end

  // Taps beyond the fill level read stale RAM, so they are forced to zero.
  always_comb begin
    x_new = new_odd_q ? rd_odd_q : rd_even_q;
    x_old = new_odd_q ? rd_even_q : rd_odd_q;
    if (!tap_new_ok_q) x_new = '0;
    if (!tap_old_ok_q) x_old = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      mac_vld_q    <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      overrun_q    <= overrun_d;
      // Accumulate one cycle after each MAC address (ROM/RAM latency).
      mac_vld_q    <= (state_q == ST_MAC);
      case (state_q)
        ST_IDLE: begin
          if (din_enable) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
            if (fill_q != FILL_MAX) fill_q <= fill_q + FW'(1);
            addr_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_MAC;
          end
        end
        ST_MAC: begin
          addr_q <= addr_q + AW'(1);
          if (addr_q == ADDR_LAST) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          busy_q       <= 1'b0;
          dout_valid_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    fir_mac_lane #(
      .DW    (DW),
      .CW    (CW),
      .ACCW  (ACCW),
      .OSHIFT(OSHIFT)
    ) u_lane (
      .clk_i   (clock),
      .rst_i   (reset),
      .clr_i   (accept),
      .acc_en_i(mac_vld_q),
      .out_en_i(out_en),
      .x_new_i (x_new),
      .x_old_i (x_old),
      .coeff_i (coeff[gi*2*CW +: 2*CW]),
      .dout_o  (dataout[gi*DW +: DW])
    );
  end

  assign busy         = busy_q;
  assign coeffaddress = addr_q;
  assign dout_valid   = dout_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_fir_bank_tdm.sv
`timescale 1ns/1ps
// Self-checking bench for fir_bank_tdm. The reference model keeps the input
// history as a queue (newest first) and evaluates the FIR sum directly.
module tb_fir_bank_tdm;

  localparam int NCH    = 8;
  localparam int NTAPS  = 128;
  localparam int DW     = 16;
  localparam int CW     = 18;
  localparam int ACCW   = 42;
  localparam int OSHIFT = 16;
  localparam int AW     = 6;
  localparam int LAT    = NTAPS / 2 + 3;

  logic                clock;
  logic                reset;
  logic [DW-1:0]       datain;
  logic                din_enable;
  logic                busy;
  logic [AW-1:0]       coeffaddress;
  logic [NCH*2*CW-1:0] coeff;
  logic [NCH*DW-1:0]   dataout;
  logic                dout_valid;
  logic                overrun;
  logic                overrun_clr;

  int h [NCH][NTAPS];
  int hq[$];
  int checks = 0;
  int errors = 0;

  fir_bank_tdm #(
    .NCH(NCH), .NTAPS(NTAPS), .DW(DW), .CW(CW), .ACCW(ACCW), .OSHIFT(OSHIFT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .datain      (datain),
    .din_enable  (din_enable),
    .busy        (busy),
    .coeffaddress(coeffaddress),
    .coeff       (coeff),
    .dataout     (dataout),
    .dout_valid  (dout_valid),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Coefficient ROMs: one-cycle read latency.
  always @(posedge clock) begin
    int a;
    a = int'(coeffaddress);
    for (int c = 0; c < NCH; c++) begin
      coeff[c*2*CW +: 2*CW] <= {CW'(h[c][2*a+1]), CW'(h[c][2*a])};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic longint model_ch(input int c);
    longint acc;
    longint hi;
    longint lo;
    acc = 0;
    for (int k = 0; k < hq.size(); k++) acc += longint'(h[c][k]) * longint'(hq[k]);
    acc = (acc + (longint'(1) <<< (OSHIFT - 1))) >>> OSHIFT;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    return acc;
  endfunction

  function automatic longint ch_out(input int c);
    return longint'($signed(dataout[c*DW +: DW]));
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    hq.delete();
    @(negedge clock);
  endtask

  // Called at a negedge; leaves at the negedge of cycle T+1.
  task automatic start_sample(input int x);
    datain = DW'(x);
    din_enable = 1'b1;
    hq.push_front(x);
    if (hq.size() > NTAPS) void'(hq.pop_back());
    @(negedge clock);
    din_enable = 1'b0;
  endtask

  // Waits for dout_valid (bounded), then checks latency and every channel.
  // Returns at the negedge of the valid cycle, so a following start_sample
  // asserts din_enable in the same cycle as dout_valid.
  task automatic finish_sample(input int cyc0, input string tag);
    int cyc;
    cyc = cyc0;
    while (dout_valid !== 1'b1 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(LAT));
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("%s_ch%0d", tag, c), 64'(ch_out(c)), 64'(model_ch(c)));
    end
  endtask

  task automatic push(input int x, input string tag);
    start_sample(x);
    check({tag, "_busy"}, 64'(busy), 64'(1));
    finish_sample(1, tag);
  endtask

  task automatic randomize_coeffs();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NTAPS; k++)
        h[c][k] = int'($urandom_range(0, 262143)) - 131072;
  endtask

  initial begin
    int rnd_in [3];
    int rnd_exp[3];
    int vcount;
    rnd_in  = '{3, -3, 1};
    rnd_exp = '{2, -1, 1};

    reset = 1'b1;
    datain = '0;
    din_enable = 1'b0;
    overrun_clr = 1'b0;
    randomize_coeffs();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(dout_valid), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_addr", 64'(coeffaddress), 64'(0));
    for (int c = 0; c < NCH; c++) check($sformatf("rst_dout%0d", c), 64'(ch_out(c)), 64'(0));

    // Impulse response on channel 0
    for (int k = 0; k < NTAPS; k++) h[0][k] = 65536;
    for (int i = 0; i < 129; i++) begin
      push((i == 0) ? 1000 : 0, "imp");
      check("imp_ch0_const", 64'(ch_out(0)), 64'((i < 128) ? 1000 : 0));
    end

    // Saturation on channel 1
    for (int k = 0; k < NTAPS; k++) h[1][k] = 65536;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(32767, "satp");
      if (i >= 1) check("satp_ch1_const", 64'(ch_out(1)), 64'(32767));
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(-32768, "satn");
      check("satn_ch1_const", 64'(ch_out(1)), 64'(-32768));
    end

    // Rounding on channel 2
    for (int k = 0; k < NTAPS; k++) h[2][k] = (k == 0) ? 32768 : 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(rnd_in[i], "rnd");
      check("rnd_ch2_const", 64'(ch_out(2)), 64'(rnd_exp[i]));
    end

    // Overrun: second strobe at T+10 dropped; clear coinciding with a new drop
    do_reset();
    start_sample(1234);
    repeat (9) @(negedge clock);
    datain = DW'(-777);
    din_enable = 1'b1;
    @(negedge clock);
    din_enable = 1'b0;
    check("ovr_set", 64'(overrun), 64'(1));
    repeat (8) @(negedge clock);
    datain = DW'(555);
    din_enable = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clock);
    din_enable = 1'b0;
    overrun_clr = 1'b0;
    check("ovr_clr_vs_set", 64'(overrun), 64'(1));
    finish_sample(20, "ovr");
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    check("ovr_cleared", 64'(overrun), 64'(0));
    push(-4321, "ovr_hist");

    // Reset mid-pass, then impulse of 500 on channel 3 with h[k]=k+1
    start_sample(9999);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_valid", 64'(dout_valid), 64'(0));
    for (int c = 0; c < NCH; c++) check($sformatf("mid_dout%0d", c), 64'(ch_out(c)), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    hq.delete();
    vcount = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (dout_valid === 1'b1) vcount++;
    end
    check("mid_no_valid", 64'(vcount), 64'(0));
    for (int k = 0; k < NTAPS; k++) h[3][k] = k + 1;
    for (int i = 0; i < 128; i++) begin
      push((i == 0) ? 500 : 0, "mid_imp");
      check("mid_imp_ch3_const", 64'(ch_out(3)), 64'((500 * (i + 1) + 32768) >>> 16));
    end

    // Wrap-around: ramp well past several wr_ptr wraps, random coefficients
    randomize_coeffs();
    do_reset();
    for (int i = 0; i < 300; i++) push(i * 200 - 30000, "wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
